stage_mem: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline. Sits between the EX/MEM latch and the MEM/WB latch.
- Passes register and HI/LO write-back information through for non-memory instructions.
- For loads and stores, runs a request/acknowledge transaction on the data bus, handling byte and halfword lanes and sign/zero extension.
- Asserts stall_request to the pipeline controller until the transaction completes.

---
 rtl/stage_mem_if.sv | 21 ++
 rtl/stage_mem.sv | 177 +++++++++++++++++
 tb/tb_stage_mem.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_mem_if.sv
// Data-bus bundle between the MIPS memory-access stage and the data memory.
// The stage drives request/address/lanes/store data; memory returns read data and a one-cycle ack.
interface stage_mem_if;
  logic        bus_request;
  logic        bus_write_enable;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_select;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_ack;

  modport master (
    output bus_request, bus_write_enable, bus_address, bus_byte_select, bus_write_data,
    input  bus_read_data, bus_ack
  );

  modport slave (
    input  bus_request, bus_write_enable, bus_address, bus_byte_select, bus_write_data,
    output bus_read_data, bus_ack
  );
endinterface

// File: rtl/stage_mem.sv
// MIPS memory-access stage: GPR/HI/LO pass-through plus a request/ack data-bus transaction for loads/stores.
// state | meaning: IDLE = no transaction | WAIT = request out, awaiting ack | DONE = result held until stall[4] clears
module stage_mem (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        ex_register_write_enable,
  input  logic [4:0]  ex_register_write_address,
  input  logic [31:0] ex_register_write_data,
  input  logic        ex_register_hi_write_enable,
  input  logic [31:0] ex_register_hi_write_data,
  input  logic        ex_register_lo_write_enable,
  input  logic [31:0] ex_register_lo_write_data,
  input  logic [3:0]  ex_memory_operation,
  input  logic [31:0] ex_memory_address,
  input  logic [31:0] ex_memory_store_data,
  output logic        mem_register_write_enable,
  output logic [4:0]  mem_register_write_address,
  output logic [31:0] mem_register_write_data,
  output logic        mem_register_hi_write_enable,
  output logic [31:0] mem_register_hi_write_data,
  output logic        mem_register_lo_write_enable,
  output logic [31:0] mem_register_lo_write_data,
  output logic        stall_request,
  output logic        address_error,
  stage_mem_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam logic [3:0] OP_LB  = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4, OP_LW = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6, OP_SH  = 4'd7, OP_SW = 4'd8;

  state_e      state_q, state_d;
  logic        bus_request_q, bus_request_d;
  logic        bus_write_enable_q, bus_write_enable_d;
  logic [31:0] bus_address_q, bus_address_d;
  logic [3:0]  bus_byte_select_q, bus_byte_select_d;
  logic [31:0] bus_write_data_q, bus_write_data_d;
  logic [31:0] load_data_q, load_data_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;

  logic        is_byte, is_half, is_word, is_load, is_store, misaligned;
  logic        op_q_is_load;
  logic [3:0]  lane_mask;
  logic [31:0] store_lanes, read_shifted, read_extended;
  logic [7:0]  read_byte;
  logic [15:0] read_half;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  always_comb begin
    is_byte    = (ex_memory_operation == OP_LB) || (ex_memory_operation == OP_LBU) ||
                 (ex_memory_operation == OP_SB);
    is_half    = (ex_memory_operation == OP_LH) || (ex_memory_operation == OP_LHU) ||
                 (ex_memory_operation == OP_SH);
    is_word    = (ex_memory_operation == OP_LW) || (ex_memory_operation == OP_SW);
    is_load    = (ex_memory_operation >= OP_LB) && (ex_memory_operation <= OP_LW);
    is_store   = (ex_memory_operation >= OP_SB) && (ex_memory_operation <= OP_SW);
    misaligned = (is_half && ex_memory_address[0]) || (is_word && (ex_memory_address[1:0] != 2'b00));

    lane_mask   = 4'b1111;
    store_lanes = ex_memory_store_data;
    if (is_byte) begin
      lane_mask   = 4'b0001 << ex_memory_address[1:0];
      store_lanes = {4{ex_memory_store_data[7:0]}};
    end else if (is_half) begin
      lane_mask   = ex_memory_address[1] ? 4'b1100 : 4'b0011;
      store_lanes = {2{ex_memory_store_data[15:0]}};
    end
    if (!is_store) store_lanes = 32'h0;
  end

  // Extension uses the op/lane captured at request time, not the (possibly changing) EX inputs.
  always_comb begin
    read_shifted = bus.bus_read_data >> {lane_q, 3'b000};
    read_byte    = read_shifted[7:0];
    read_half    = lane_q[1] ? bus.bus_read_data[31:16] : bus.bus_read_data[15:0];
    case (op_q)
      OP_LB:   read_extended = {{24{read_byte[7]}}, read_byte};
      OP_LBU:  read_extended = {24'h0, read_byte};
      OP_LH:   read_extended = {{16{read_half[15]}}, read_half};
      OP_LHU:  read_extended = {16'h0, read_half};
      default: read_extended = bus.bus_read_data;
    endcase
    op_q_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);
  end

  always_comb begin
    state_d            = state_q;
    bus_request_d      = bus_request_q;
    bus_write_enable_d = bus_write_enable_q;
    bus_address_d      = bus_address_q;
    bus_byte_select_d  = bus_byte_select_q;
    bus_write_data_d   = bus_write_data_q;
    load_data_d        = load_data_q;
    op_d               = op_q;
    lane_d             = lane_q;
    stall_request      = 1'b0;
    address_error      = 1'b0;

    mem_register_write_enable    = ex_register_write_enable;
    mem_register_write_address   = ex_register_write_address;
    mem_register_write_data      = ex_register_write_data;
    mem_register_hi_write_enable = ex_register_hi_write_enable;
    mem_register_hi_write_data   = ex_register_hi_write_data;
    mem_register_lo_write_enable = ex_register_lo_write_enable;
    mem_register_lo_write_data   = ex_register_lo_write_data;

    case (state_q)
      IDLE: begin
        if (is_load || is_store) begin
          if (misaligned) begin
            address_error             = 1'b1;
            mem_register_write_enable = 1'b0;
          end else begin
            stall_request      = 1'b1;
            state_d            = WAIT;
            bus_request_d      = 1'b1;
            bus_write_enable_d = is_store;
            bus_address_d      = {ex_memory_address[31:2], 2'b00};
            bus_byte_select_d  = lane_mask;
            bus_write_data_d   = store_lanes;
            op_d               = ex_memory_operation;
            lane_d             = ex_memory_address[1:0];
          end
        end
      end
      WAIT: begin
        stall_request = 1'b1;
        if (bus.bus_ack) begin
          bus_request_d = 1'b0;
          load_data_d   = read_extended;
          state_d       = DONE;
        end
      end
      DONE: begin
        if (op_q_is_load) mem_register_write_data = load_data_q;
        if (!stall[4]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q            <= IDLE;
      bus_request_q      <= 1'b0;
      bus_write_enable_q <= 1'b0;
      bus_address_q      <= 32'h0;
      bus_byte_select_q  <= 4'h0;
      bus_write_data_q   <= 32'h0;
      load_data_q        <= 32'h0;
      op_q               <= 4'h0;
      lane_q             <= 2'b00;
    end else begin
      state_q            <= state_d;
      bus_request_q      <= bus_request_d;
      bus_write_enable_q <= bus_write_enable_d;
      bus_address_q      <= bus_address_d;
      bus_byte_select_q  <= bus_byte_select_d;
      bus_write_data_q   <= bus_write_data_d;
      load_data_q        <= load_data_d;
      op_q               <= op_d;
      lane_q             <= lane_d;
    end
  end

  assign bus.bus_request      = bus_request_q;
  assign bus.bus_write_enable = bus_write_enable_q;
  assign bus.bus_address      = bus_address_q;
  assign bus.bus_byte_select  = bus_byte_select_q;
  assign bus.bus_write_data   = bus_write_data_q;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: driver pushes expected results/bus transfers, monitors pop and compare.
module tb_stage_mem;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [5:0]  stall;
  logic        ex_we, ex_hi_we, ex_lo_we;
  logic [4:0]  ex_wa;
  logic [31:0] ex_wd, ex_hi, ex_lo, ex_addr, ex_sd;
  logic [3:0]  ex_op;
  logic        m_we, m_hi_we, m_lo_we, stall_request, address_error;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_hi, m_lo;

  stage_mem_if bus_if ();

  stage_mem dut (
    .clock(clock), .reset(reset), .stall(stall),
    .ex_register_write_enable(ex_we), .ex_register_write_address(ex_wa),
    .ex_register_write_data(ex_wd),
    .ex_register_hi_write_enable(ex_hi_we), .ex_register_hi_write_data(ex_hi),
    .ex_register_lo_write_enable(ex_lo_we), .ex_register_lo_write_data(ex_lo),
    .ex_memory_operation(ex_op), .ex_memory_address(ex_addr), .ex_memory_store_data(ex_sd),
    .mem_register_write_enable(m_we), .mem_register_write_address(m_wa),
    .mem_register_write_data(m_wd),
    .mem_register_hi_write_enable(m_hi_we), .mem_register_hi_write_data(m_hi),
    .mem_register_lo_write_enable(m_lo_we), .mem_register_lo_write_data(m_lo),
    .stall_request(stall_request), .address_error(address_error),
    .bus(bus_if.master)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hi_we;
    logic [31:0] hi;
    logic        lo_we;
    logic [31:0] lo;
    logic        aerr;
    int          stall_cyc;
  } res_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  bsel;
    logic [31:0] wdata;
  } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];
  int   total = 0;
  int   bad = 0;
  logic valid = 1'b0;
  int   rsp_delay = 0;
  logic [31:0] rsp_data = 32'h0;
  bit   rsp_en = 1'b1;
  bit   abort = 1'b0;
  int   scnt = 0;
  int   rcnt = 0;
  logic prev_req = 1'b0;
  res_t mon_r;
  bus_t cur_b;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(int op);
    if (op == 1 || op == 2 || op == 6) return 1;
    if (op == 3 || op == 4 || op == 7) return 2;
    if (op == 5 || op == 8) return 4;
    return 0;
  endfunction

  // Reference extension: pick the addressed byte/halfword numerically, then extend.
  function automatic logic [31:0] ext(int op, logic [31:0] addr, logic [31:0] rd);
    int lane;
    logic [31:0] b, h;
    lane = int'(addr % 4);
    b = (rd >> (8 * lane)) & 32'hFF;
    h = (rd >> (16 * (lane / 2))) & 32'hFFFF;
    case (op)
      1: return (b >= 128) ? b - 32'd256 : b;
      2: return b;
      3: return (h >= 32768) ? h - 32'd65536 : h;
      4: return h;
      default: return rd;
    endcase
  endfunction

  task automatic issue(int op, logic [31:0] addr, logic [31:0] sd, logic [31:0] rd, int delay,
                       int hold, logic we, logic [4:0] wa, logic [31:0] wd,
                       logic hi_we, logic [31:0] hi);
    res_t r;
    bus_t b;
    int   sz;
    bit   mem, mis, st, done;
    sz  = size_of(op);
    mem = (sz != 0);
    mis = mem && ((addr % sz) != 0);
    r.we = mis ? 1'b0 : we;
    r.wa = wa;
    r.wd = (mem && !mis && op <= 5) ? ext(op, addr, rd) : wd;
    r.hi_we = hi_we;
    r.hi = hi;
    r.lo_we = ~hi_we;
    r.lo = ~hi;
    r.aerr = mis;
    r.stall_cyc = (mem && !mis) ? delay + 2 : 0;
    if (mem && !mis) begin
      b.we    = (op >= 6);
      b.addr  = addr & 32'hFFFF_FFFC;
      b.bsel  = 4'(((32'd1 << sz) - 32'd1) << (addr % 4));
      b.wdata = (sz == 1) ? {24'h0, sd[7:0]} * 32'h0101_0101 :
                (sz == 2) ? {16'h0, sd[15:0]} * 32'h0001_0001 : sd;
      bus_q.push_back(b);
    end
    res_q.push_back(r);
    rsp_data  = rd;
    rsp_delay = delay;
    ex_op = 4'(op); ex_addr = addr; ex_sd = sd; ex_we = we; ex_wa = wa; ex_wd = wd;
    ex_hi_we = hi_we; ex_hi = hi; ex_lo_we = ~hi_we; ex_lo = ~hi;
    stall[4] = (hold > 0);
    valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      st = stall_request;
      @(posedge clock);
      #1;
      if (!st && !stall[4]) begin
        done = 1'b1;
        break;
      end
      if (!st) begin
        hold--;
        if (hold <= 0) stall[4] = 1'b0;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL retire_timeout actual=no_retire required=retire op=%0d", op);
      abort = 1'b1;
    end
    valid = 1'b0;
    ex_op = 4'd0;
    stall[4] = 1'b0;
  endtask

  // Memory model: ack after rsp_delay request cycles, stray acks while idle.
  always @(negedge clock) begin
    if (rsp_en) begin
      if (bus_if.bus_request) begin
        if (rcnt == rsp_delay) begin
          bus_if.bus_ack = 1'b1;
          bus_if.bus_read_data = rsp_data;
        end else begin
          bus_if.bus_ack = 1'b0;
          bus_if.bus_read_data = $urandom;
        end
        rcnt++;
      end else begin
        rcnt = 0;
        bus_if.bus_ack = ($urandom % 4 == 0);
        bus_if.bus_read_data = $urandom;
      end
    end
  end

  always @(negedge clock) begin
    if (valid && stall_request) scnt++;
    if (valid && !stall_request) begin
      if (res_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL result_unexpected actual=output required=none");
      end else begin
        mon_r = res_q[0];
        chk("wr_en", {31'h0, m_we}, {31'h0, mon_r.we});
        chk("wr_addr", {27'h0, m_wa}, {27'h0, mon_r.wa});
        chk("wr_data", m_wd, mon_r.wd);
        chk("hi_en", {31'h0, m_hi_we}, {31'h0, mon_r.hi_we});
        chk("hi_data", m_hi, mon_r.hi);
        chk("lo_en", {31'h0, m_lo_we}, {31'h0, mon_r.lo_we});
        chk("lo_data", m_lo, mon_r.lo);
        chk("addr_err", {31'h0, address_error}, {31'h0, mon_r.aerr});
        if (!stall[4]) begin
          chk("stall_cycles", 32'(scnt), 32'(mon_r.stall_cyc));
          void'(res_q.pop_front());
          scnt = 0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (bus_if.bus_request) begin
      if (!prev_req) begin
        if (bus_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bus_unexpected actual=request required=none");
          cur_b.we = 1'bx;
        end else begin
          cur_b = bus_q.pop_front();
        end
      end
      chk("bus_we", {31'h0, bus_if.bus_write_enable}, {31'h0, cur_b.we});
      chk("bus_addr", bus_if.bus_address, cur_b.addr);
      chk("bus_bsel", {28'h0, bus_if.bus_byte_select}, {28'h0, cur_b.bsel});
      if (cur_b.we === 1'b1) chk("bus_wdata", bus_if.bus_write_data, cur_b.wdata);
    end
    prev_req = bus_if.bus_request;
  end

  task automatic rand_op();
    int op, dl, hd;
    logic [31:0] a;
    op = int'($urandom % 16);
    a  = $urandom;
    if ($urandom % 2 == 0) a[1:0] = 2'b00;
    dl = int'($urandom % 6);
    hd = ($urandom % 4 == 0) ? int'($urandom_range(1, 2)) : 0;
    issue(op, a, $urandom, $urandom, dl, hd, 1'($urandom), 5'($urandom), $urandom,
          1'($urandom), $urandom);
  endtask

  initial begin
    reset = 1'b0; stall = 6'h0; ex_op = 4'd0; ex_addr = 32'h0; ex_sd = 32'h0;
    ex_we = 1'b0; ex_wa = 5'd0; ex_wd = 32'h0; ex_hi_we = 1'b0; ex_hi = 32'h0;
    ex_lo_we = 1'b0; ex_lo = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_read_data = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_bus_req", {31'h0, bus_if.bus_request}, 32'h0);
    chk("rst_bus_we", {31'h0, bus_if.bus_write_enable}, 32'h0);
    chk("rst_bus_addr", bus_if.bus_address, 32'h0);
    chk("rst_bus_bsel", {28'h0, bus_if.bus_byte_select}, 32'h0);
    chk("rst_bus_wdata", bus_if.bus_write_data, 32'h0);
    chk("rst_stall_req", {31'h0, stall_request}, 32'h0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    issue(0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1, 5'd3, 32'h1234_5678, 1'b1, 32'hAAAA_0000);
    issue(1, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0, 1'b1, 5'd4, 32'h0, 1'b0, 32'h0);
    issue(2, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0, 1'b1, 5'd5, 32'h0, 1'b0, 32'h0);
    issue(7, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    issue(5, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 4, 2, 1'b1, 5'd7, 32'h0, 1'b0, 32'h0);
    issue(5, 32'h0000_0006, 32'h0, 32'h0, 0, 0, 1'b1, 5'd8, 32'h0BAD_0BAD, 1'b0, 32'h0);
    issue(3, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 1, 0, 1'b1, 5'd9, 32'h0, 1'b0, 32'h0);
    issue(4, 32'h0000_0040, 32'h0, 32'h8001_8FFF, 2, 0, 1'b1, 5'd9, 32'h0, 1'b0, 32'h0);
    issue(6, 32'h0000_0051, 32'h0000_00A5, 32'h0, 3, 1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    issue(8, 32'h0000_0060, 32'h1357_9BDF, 32'h0, 0, 0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 200 && !abort; i++) rand_op();

    if (!abort) begin
      bus_q.push_back('{we: 1'b0, addr: 32'h0000_3000, bsel: 4'hF, wdata: 32'h0});
      rsp_delay = 1000;
      ex_op = 4'd5; ex_addr = 32'h0000_3000; ex_we = 1'b1; ex_wd = 32'h0000_5555;
      repeat (3) @(posedge clock);
      #1;
      chk("wait_stall_req", {31'h0, stall_request}, 32'h1);
      reset = 1'b0;
      ex_op = 4'd0;
      @(posedge clock);
      #1;
      chk("midrst_bus_req", {31'h0, bus_if.bus_request}, 32'h0);
      chk("midrst_bus_we", {31'h0, bus_if.bus_write_enable}, 32'h0);
      chk("midrst_bus_addr", bus_if.bus_address, 32'h0);
      chk("midrst_bus_bsel", {28'h0, bus_if.bus_byte_select}, 32'h0);
      chk("midrst_bus_wdata", bus_if.bus_write_data, 32'h0);
      chk("midrst_stall_req", {31'h0, stall_request}, 32'h0);
      reset = 1'b1;
      rsp_en = 1'b0;
      bus_if.bus_ack = 1'b1;
      bus_if.bus_read_data = 32'hFFFF_FFFF;
      repeat (2) @(posedge clock);
      #1;
      chk("late_ack_bus_req", {31'h0, bus_if.bus_request}, 32'h0);
      chk("late_ack_stall_req", {31'h0, stall_request}, 32'h0);
      chk("late_ack_wr_data", m_wd, 32'h0000_5555);
      bus_if.bus_ack = 1'b0;
      rsp_en = 1'b1;
      rsp_delay = 0;
      for (int i = 0; i < 30 && !abort; i++) rand_op();
    end

    repeat (2) @(posedge clock);
    chk("res_queue_empty", 32'(res_q.size()), 32'h0);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
